// File: rtl/ram_stream_reader.sv
// Burst reader for a 1-cycle registered-read RAM: issues LENGTH reads from BASE (wrapping),
// and streams the words out through a 4-entry FIFO under a credit scheme that never overflows it.
module ram_stream_reader #(
    parameter int SIZE  = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [AW-1:0]   base_addr,
    input  logic [LW-1:0]   length,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic [AW-1:0]   raddr,
    input  logic [SIZE-1:0] read_data,
    output logic [SIZE-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_raddr;
    logic [AW-1:0]   w_raddr_nxt;
    logic [LW-1:0]   r_remain;
    logic [LW-1:0]   w_remain_nxt;
    logic [1:0]      r_pipe;
    logic [1:0]      w_pipe_nxt;
    logic [2:0]      r_count;
    logic [2:0]      w_count_nxt;
    logic [SIZE-1:0] r_fifo [0:3];
    logic [SIZE-1:0] w_fifo_nxt [0:3];
    logic            r_done;
    logic            w_done_nxt;

    logic            w_first;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    logic            w_valid;
    logic            w_credit_ok;
    logic [2:0]      w_inflight;
    logic [3:0]      w_credit_used;
    logic [2:0]      w_wr_idx;

    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        if (a == AW'(DEPTH - 1)) begin
            r = '0;
        end else begin
            r = a + AW'(1);
        end
        return r;
    endfunction

    // Credit bookkeeping: FIFO occupancy plus reads still travelling through the RAM
    always_comb begin
        w_valid       = (r_count != 3'd0);
        w_pop         = w_valid & out_ready;
        w_push        = r_pipe[1];
        w_inflight    = {2'b00, r_pipe[0]} + {2'b00, r_pipe[1]};
        w_credit_used = {1'b0, r_count} + {1'b0, w_inflight};
        w_credit_ok   = (w_credit_used < 4'd4);
    end

    // Next-state and issue decisions; abort overrides everything
    always_comb begin
        w_state_nxt  = r_state;
        w_first      = 1'b0;
        w_issue      = 1'b0;
        w_done_nxt   = 1'b0;
        w_remain_nxt = r_remain;
        w_raddr_nxt  = r_raddr;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (length != LW'(0)) begin
                            w_first      = 1'b1;
                            w_raddr_nxt  = base_addr;
                            w_remain_nxt = length - LW'(1);
                            w_state_nxt  = (length == LW'(1)) ? S_DRAIN : S_READ;
                        end else begin
                            w_done_nxt = 1'b1;
                        end
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_READ: begin
                    if (w_credit_ok) begin
                        w_issue      = 1'b1;
                        w_raddr_nxt  = addr_inc(r_raddr);
                        w_remain_nxt = r_remain - LW'(1);
                        if (r_remain == LW'(1)) begin
                            w_state_nxt = S_DRAIN;
                        end else begin
                            w_state_nxt = S_READ;
                        end
                    end else begin
                        w_state_nxt = S_READ;
                    end
                end
                S_DRAIN: begin
                    // final word: last FIFO entry leaves with nothing left in the RAM pipe
                    if (w_pop && (r_count == 3'd1) && (r_pipe == 2'b00)) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_DRAIN;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Issue-flag shift pipe and shift-register FIFO next values
    always_comb begin
        w_pipe_nxt = abort ? 2'b00 : {r_pipe[0], w_first | w_issue};
        for (int i = 0; i < 4; i++) begin
            w_fifo_nxt[i] = r_fifo[i];
        end
        if (w_pop) begin
            for (int i = 0; i < 3; i++) begin
                w_fifo_nxt[i] = r_fifo[i + 1];
            end
        end else begin
            w_fifo_nxt[3] = r_fifo[3];
        end
        w_wr_idx = r_count - {2'b00, w_pop};
        if (w_push && (w_wr_idx < 3'd4)) begin
            w_fifo_nxt[w_wr_idx[1:0]] = read_data;
        end else begin
            w_fifo_nxt[3] = w_fifo_nxt[3];
        end
        if (abort) begin
            w_count_nxt = 3'd0;
        end else begin
            w_count_nxt = r_count - {2'b00, w_pop} + {2'b00, w_push};
        end
    end

    // State, address, counters and FIFO registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_raddr  <= '0;
            r_remain <= '0;
            r_pipe   <= 2'b00;
            r_count  <= 3'd0;
            r_done   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            r_state  <= w_state_nxt;
            r_raddr  <= w_raddr_nxt;
            r_remain <= w_remain_nxt;
            r_pipe   <= w_pipe_nxt;
            r_count  <= w_count_nxt;
            r_done   <= w_done_nxt;
            for (int i = 0; i < 4; i++) begin
                r_fifo[i] <= w_fifo_nxt[i];
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign raddr     = r_raddr;
    assign out_data  = r_fifo[0];
    assign out_valid = w_valid;

endmodule
